// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: walks the output pixels of one conv layer in row-major order and
// issues window fetches to the line store. o_valid rises MEM_LATENCY cycles after fetch_req.
// o_valid, win_row, win_col and last_pixel are held until pe_ack. Optional SCHED_STALL_CNT_EN
// adds a saturating count of unacknowledged valid cycles.
module conv_window_scheduler #(
  parameter int IN_WIDTH    = 513,
  parameter int IN_HEIGHT   = 257,
  parameter int KERNEL_0    = 3,
  parameter int KERNEL_1    = 3,
  parameter int DILATION_0  = 2,
  parameter int DILATION_1  = 2,
  parameter int PADDING_0   = 2,
  parameter int PADDING_1   = 2,
  parameter int STRIDE_0    = 1,
  parameter int STRIDE_1    = 1,
  parameter int MEM_LATENCY = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  output logic                                       fetch_req,
  output logic signed [$clog2(IN_HEIGHT+PADDING_0):0] win_row,
  output logic signed [$clog2(IN_WIDTH+PADDING_1):0]  win_col,
  output logic                                       o_valid,
  input  logic                                       pe_ack,
  output logic                                       last_pixel,
  output logic                                       busy,
  output logic                                       done,
  output logic [31:0]                                stall_cnt
);

  localparam int OUT_H = (IN_HEIGHT + 2*PADDING_0 - DILATION_0*(KERNEL_0-1) - 1) / STRIDE_0 + 1;
  localparam int OUT_W = (IN_WIDTH + 2*PADDING_1 - DILATION_1*(KERNEL_1-1) - 1) / STRIDE_1 + 1;
  localparam int RW = $clog2(IN_HEIGHT+PADDING_0) + 1;
  localparam int CW = $clog2(IN_WIDTH+PADDING_1) + 1;
  localparam int RB = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int CB = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  // Latency counter only needs to reach MEM_LATENCY-1.
  localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  localparam logic [RB-1:0] ROW_LAST = RB'(OUT_H - 1);
  localparam logic [CB-1:0] COL_LAST = CB'(OUT_W - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(MEM_LATENCY - 1);
  localparam logic signed [RW-1:0] ROW_ORIGIN0 = RW'(-PADDING_0);
  localparam logic signed [CW-1:0] COL_ORIGIN0 = CW'(-PADDING_1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_VALID,
    S_DONE
  } state_t;

  state_t        state;
  logic [RB-1:0] row_cnt;
  logic [RB-1:0] row_nxt;
  logic [CB-1:0] col_cnt;
  logic [CB-1:0] col_nxt;
  logic [LW-1:0] lat_cnt;
  logic          at_last;

  // Top-left input coordinate of the window for a given output row/col.
  function automatic logic signed [RW-1:0] row_origin(input logic [RB-1:0] r);
    return RW'(int'(r) * STRIDE_0 - PADDING_0);
  endfunction

  function automatic logic signed [CW-1:0] col_origin(input logic [CB-1:0] c);
    return CW'(int'(c) * STRIDE_1 - PADDING_1);
  endfunction

  // Next raster position: the column wraps to 0 and carries into the row.
  always_comb begin
    at_last = (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);
    row_nxt = row_cnt;
    col_nxt = col_cnt + 1'b1;
    if (col_cnt == COL_LAST) begin
      col_nxt = '0;
      row_nxt = row_cnt + 1'b1;
    end
  end

  // Frame sequencer with registered outputs; window coordinates only move on an accepted window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      row_cnt    <= '0;
      col_cnt    <= '0;
      lat_cnt    <= '0;
      fetch_req  <= 1'b0;
      o_valid    <= 1'b0;
      last_pixel <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      win_row    <= ROW_ORIGIN0;
      win_col    <= COL_ORIGIN0;
    end else begin
      fetch_req <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            fetch_req <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_FETCH: begin
          lat_cnt <= LW'(1);
          if (MEM_LATENCY == 1) begin
            state      <= S_VALID;
            o_valid    <= 1'b1;
            last_pixel <= at_last;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            state      <= S_VALID;
            o_valid    <= 1'b1;
            last_pixel <= at_last;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_VALID: begin
          if (pe_ack) begin
            o_valid    <= 1'b0;
            last_pixel <= 1'b0;
            if (last_pixel) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              row_cnt   <= row_nxt;
              col_cnt   <= col_nxt;
              win_row   <= row_origin(row_nxt);
              win_col   <= col_origin(col_nxt);
              state     <= S_FETCH;
              fetch_req <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          row_cnt <= '0;
          col_cnt <= '0;
          win_row <= ROW_ORIGIN0;
          win_col <= COL_ORIGIN0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SCHED_STALL_CNT_EN
  // Count valid cycles left unacknowledged by the PE controller, saturating, restarting per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      stall_cnt <= '0;
    end else if (state == S_VALID && !pe_ack && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler: three instances (5x3 L=2, 5x3 L=3, 1x1 L=2) driven with
// random acknowledge delays and spurious acks, checked against a raster model of expected windows.
module tb_conv_window_scheduler;

  localparam int RW0 = $clog2(3+2) + 1;
  localparam int CW0 = $clog2(5+2) + 1;
  localparam int RW2 = $clog2(1+0) + 1;
  localparam int CW2 = $clog2(1+0) + 1;

  // Reference geometry per instance, straight from the layer formulas.
  localparam int OH[3]  = '{3, 3, 1};
  localparam int OW[3]  = '{5, 5, 1};
  localparam int PR[3]  = '{2, 2, 0};
  localparam int PC[3]  = '{2, 2, 0};
  localparam int LAT[3] = '{2, 3, 2};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a[3] = '{1'b0, 1'b0, 1'b0};
  logic ack_a[3]   = '{1'b0, 1'b0, 1'b0};

  logic fetch_a[3], vld_a[3], last_a[3], busy_a[3], done_a[3];
  int   row_a[3], col_a[3];
  logic [31:0] stall_a[3];

  logic signed [RW0-1:0] wr0, wr1;
  logic signed [CW0-1:0] wc0, wc1;
  logic signed [RW2-1:0] wr2;
  logic signed [CW2-1:0] wc2;

  assign row_a[0] = int'(wr0);
  assign row_a[1] = int'(wr1);
  assign row_a[2] = int'(wr2);
  assign col_a[0] = int'(wc0);
  assign col_a[1] = int'(wc1);
  assign col_a[2] = int'(wc2);

  conv_window_scheduler #(
    .IN_WIDTH(5), .IN_HEIGHT(3), .KERNEL_0(3), .KERNEL_1(3), .DILATION_0(2), .DILATION_1(2),
    .PADDING_0(2), .PADDING_1(2), .STRIDE_0(1), .STRIDE_1(1), .MEM_LATENCY(2)
  ) u_dut0 (
    .clk(clk), .rst(rst), .start(start_a[0]), .fetch_req(fetch_a[0]), .win_row(wr0), .win_col(wc0),
    .o_valid(vld_a[0]), .pe_ack(ack_a[0]), .last_pixel(last_a[0]), .busy(busy_a[0]),
    .done(done_a[0]), .stall_cnt(stall_a[0])
  );

  conv_window_scheduler #(
    .IN_WIDTH(5), .IN_HEIGHT(3), .KERNEL_0(3), .KERNEL_1(3), .DILATION_0(2), .DILATION_1(2),
    .PADDING_0(2), .PADDING_1(2), .STRIDE_0(1), .STRIDE_1(1), .MEM_LATENCY(3)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start_a[1]), .fetch_req(fetch_a[1]), .win_row(wr1), .win_col(wc1),
    .o_valid(vld_a[1]), .pe_ack(ack_a[1]), .last_pixel(last_a[1]), .busy(busy_a[1]),
    .done(done_a[1]), .stall_cnt(stall_a[1])
  );

  conv_window_scheduler #(
    .IN_WIDTH(1), .IN_HEIGHT(1), .KERNEL_0(1), .KERNEL_1(1), .DILATION_0(1), .DILATION_1(1),
    .PADDING_0(0), .PADDING_1(0), .STRIDE_0(1), .STRIDE_1(1), .MEM_LATENCY(2)
  ) u_dut2 (
    .clk(clk), .rst(rst), .start(start_a[2]), .fetch_req(fetch_a[2]), .win_row(wr2), .win_col(wc2),
    .o_valid(vld_a[2]), .pe_ack(ack_a[2]), .last_pixel(last_a[2]), .busy(busy_a[2]),
    .done(done_a[2]), .stall_cnt(stall_a[2])
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model state shared between the per-instance monitors/drivers and the main sequence.
  int idx_m[3]      = '{0, 0, 0};
  int nfetch[3]     = '{0, 0, 0};
  int ndone[3]      = '{0, 0, 0};
  int hold_total[3] = '{0, 0, 0};
  int vlen_at[3][16];
  int hold_pix[3]   = '{-1, -1, -1};
  int hold_n[3]     = '{0, 0, 0};
  bit rand_hold[3]  = '{1'b0, 1'b0, 1'b0};
  bit spur[3]       = '{1'b0, 1'b0, 1'b0};

  for (genvar g = 0; g < 3; g++) begin : g_inst
    int   since = -1;
    int   vlen = 0;
    bit   pv = 1'b0;
    bit   pf = 1'b0;
    bit   pend_done = 1'b0;
    bit   busy_low_next = 1'b0;
    int   prow = 0;
    int   pcol = 0;
    logic plast = 1'b0;
    int   left = -1;

    // Monitor: compares each presented window with the next raster position of the model.
    always @(negedge clk) begin
      if (rst) begin
        idx_m[g] = 0;
        since = -1;
        pv = 1'b0;
        pf = 1'b0;
        pend_done = 1'b0;
        busy_low_next = 1'b0;
      end else begin
        if (busy_low_next) begin
          check($sformatf("busy_low_after_done[%0d]", g), busy_a[g], 0);
          busy_low_next = 1'b0;
        end
        if (pend_done) begin
          check($sformatf("done_after_last_ack[%0d]", g), done_a[g], 1);
          check($sformatf("busy_in_done[%0d]", g), busy_a[g], 1);
          pend_done = 1'b0;
          busy_low_next = 1'b1;
          if (done_a[g]) ndone[g]++;
          idx_m[g] = 0;
        end else if (done_a[g]) begin
          check($sformatf("unexpected_done[%0d]", g), done_a[g], 0);
          ndone[g]++;
        end
        if (fetch_a[g]) begin
          check($sformatf("fetch_one_cycle[%0d]", g), pf, 0);
          since = 0;
          nfetch[g]++;
        end else if (since >= 0) begin
          since++;
        end
        if (vld_a[g] && !pv) begin
          check($sformatf("fetch_to_valid[%0d]", g), since, LAT[g]);
          check($sformatf("win_row[%0d]#%0d", g, idx_m[g]), row_a[g], idx_m[g] / OW[g] - PR[g]);
          check($sformatf("win_col[%0d]#%0d", g, idx_m[g]), col_a[g], idx_m[g] % OW[g] - PC[g]);
          check($sformatf("last_pixel[%0d]#%0d", g, idx_m[g]), last_a[g],
                (idx_m[g] == OH[g]*OW[g] - 1) ? 1 : 0);
          vlen = 0;
        end else if (vld_a[g] && pv) begin
          check($sformatf("hold_stable[%0d]", g),
                {row_a[g] != prow, col_a[g] != pcol, last_a[g] != plast}, 0);
        end
        if (vld_a[g]) begin
          vlen++;
          if (ack_a[g]) begin
            if (idx_m[g] < 16) vlen_at[g][idx_m[g]] = vlen;
            idx_m[g]++;
            if (idx_m[g] == OH[g]*OW[g]) pend_done = 1'b1;
          end
        end
        pv = vld_a[g];
        pf = fetch_a[g];
        prow = row_a[g];
        pcol = col_a[g];
        plast = last_a[g];
      end
    end

    // Acknowledge driver: optional per-window hold, else same-cycle ack; optional spurious acks.
    always @(posedge clk) begin
      #1;
      if (rst) begin
        ack_a[g] = 1'b0;
        left = -1;
      end else if (vld_a[g]) begin
        if (left < 0) begin
          if (idx_m[g] == hold_pix[g]) left = hold_n[g];
          else if (rand_hold[g]) left = int'($urandom_range(0, 3));
          else left = 0;
          hold_total[g] += left;
        end
        if (left > 0) begin
          ack_a[g] = 1'b0;
          left--;
        end else begin
          ack_a[g] = 1'b1;
          left = -1;
        end
      end else begin
        ack_a[g] = spur[g] ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  function automatic int exp_stall(input int holds);
`ifdef SCHED_STALL_CNT_EN
    return holds;
`else
    return 0 * holds;
`endif
  endfunction

  task automatic run_frame(input int k, input bit spam);
    int  f0, d0, h0, c;
    bit  seen;
    f0 = nfetch[k];
    d0 = ndone[k];
    h0 = hold_total[k];
    seen = 1'b0;
    c = 0;
    @(posedge clk); #1 start_a[k] = 1'b1;
    @(posedge clk); #1 start_a[k] = 1'b0;
    while (!seen && c < 600) begin
      @(posedge clk); #1;
      c++;
      if (done_a[k]) begin
        seen = 1'b1;
        start_a[k] = spam;
      end else begin
        start_a[k] = spam && ($urandom_range(0, 2) == 0);
      end
    end
    @(posedge clk); #1 start_a[k] = 1'b0;
    check($sformatf("frame_done_seen[%0d]", k), seen, 1);
    repeat (6) @(posedge clk);
    #1;
    check($sformatf("busy_idle_after[%0d]", k), busy_a[k], 0);
    check($sformatf("fetch_count[%0d]", k), nfetch[k] - f0, OH[k]*OW[k]);
    check($sformatf("done_count[%0d]", k), ndone[k] - d0, 1);
    check($sformatf("stall_cnt[%0d]", k), stall_a[k], exp_stall(hold_total[k] - h0));
  endtask

  initial begin
    int c, d0;
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_fetch[%0d]", k), fetch_a[k], 0);
      check($sformatf("rst_valid[%0d]", k), vld_a[k], 0);
      check($sformatf("rst_busy[%0d]", k), busy_a[k], 0);
      check($sformatf("rst_done[%0d]", k), done_a[k], 0);
      check($sformatf("rst_last[%0d]", k), last_a[k], 0);
      check($sformatf("rst_row[%0d]", k), row_a[k], -PR[k]);
      check($sformatf("rst_col[%0d]", k), col_a[k], -PC[k]);
      check($sformatf("rst_stall[%0d]", k), stall_a[k], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Same-cycle acknowledge: back-to-back windows at full throughput.
    run_frame(0, 1'b0);

    // Pixel 7 held 4 cycles, with start pulses mid-frame and in the done cycle.
    hold_pix[0] = 6;
    hold_n[0] = 4;
    run_frame(0, 1'b1);
    check("pixel7_valid_cycles", vlen_at[0][6], 5);
    hold_pix[0] = -1;

    // Longer memory latency with random holds and spurious acks outside VALID.
    rand_hold[1] = 1'b1;
    spur[1] = 1'b1;
    run_frame(1, 1'b0);
    run_frame(1, 1'b1);

    // Random frame, then asynchronous reset while pixel 9 is presented.
    rand_hold[0] = 1'b1;
    spur[0] = 1'b1;
    run_frame(0, 1'b0);
    d0 = ndone[0];
    @(posedge clk); #1 start_a[0] = 1'b1;
    @(posedge clk); #1 start_a[0] = 1'b0;
    c = 0;
    while (!(idx_m[0] == 8 && vld_a[0]) && c < 400) begin
      @(posedge clk); #1;
      c++;
    end
    check("reached_pixel9", (idx_m[0] == 8 && vld_a[0]) ? 1 : 0, 1);
    rst = 1'b1;
    #1;
    check("midrst_valid", vld_a[0], 0);
    check("midrst_fetch", fetch_a[0], 0);
    check("midrst_busy", busy_a[0], 0);
    check("midrst_last", last_a[0], 0);
    check("midrst_row", row_a[0], -2);
    check("midrst_col", col_a[0], -2);
    check("midrst_stall", stall_a[0], 0);
    @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_done", ndone[0] - d0, 0);
    run_frame(0, 1'b0);

    // Single-pixel frame.
    rand_hold[2] = 1'b1;
    spur[2] = 1'b1;
    run_frame(2, 1'b0);
    run_frame(2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
